// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - registered fetch program counter with branch/jump redirect, stall capture and halt
module pc_gen #(
  parameter int               WIDTH     = 16,
  parameter int               OFF_W     = 9,
  parameter int               OFF_SHIFT = 1,
  parameter int               INC       = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_base,
  input  logic [OFF_W-1:0] br_off,
  input  logic             jr_taken,
  input  logic [WIDTH-1:0] jr_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             halted,
  output logic             pend,
  output logic             wrap
);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    STALLED_PEND = 2'd1,
    HALTED       = 2'd2
  } state_t;

  // The increment is widened by one bit so the carry out of the PC is visible.
  localparam logic [WIDTH:0] INC_EXT = (WIDTH+1)'(INC);

  state_t           state, state_n;
  logic [WIDTH-1:0] pc_n;
  logic [WIDTH-1:0] pend_tgt, pend_tgt_n;
  logic             wrap_n;
  logic [WIDTH:0]   seq_sum;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] br_tgt;
  logic             redir;
  logic [WIDTH-1:0] redir_tgt;

  // Sequential address, branch target and redirect selection; all wrap modulo 2^WIDTH.
  always_comb begin
    seq_sum   = {1'b0, pc} + INC_EXT;
    pc_seq    = seq_sum[WIDTH-1:0];
    off_ext   = WIDTH'($signed(br_off));
    br_tgt    = br_base + (off_ext << OFF_SHIFT);
    redir     = br_taken | jr_taken;
    redir_tgt = jr_taken ? jr_target : br_tgt;
  end

  // Next-PC priority: live redirect, stalled capture, pending replay, halt, stall, increment.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_tgt_n = pend_tgt;
    wrap_n     = wrap;
    if (redir && !stall) begin
      pc_n    = redir_tgt;
      state_n = RUN;
    end else if (redir && stall) begin
      pend_tgt_n = redir_tgt;
      state_n    = STALLED_PEND;
    end else if ((state == STALLED_PEND) && !stall) begin
      pc_n    = pend_tgt;
      state_n = RUN;
    end else if (state == HALTED) begin
      state_n = HALTED;
    end else if (halt && !stall) begin
      state_n = HALTED;
    end else if (stall) begin
      pc_n = pc;
    end else begin
      pc_n = seq_sum[WIDTH-1:0];
      if (seq_sum[WIDTH]) begin
        wrap_n = 1'b1;
      end
    end
  end

  // State, PC, captured target and sticky wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_VEC;
      pend_tgt <= '0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      pend_tgt <= pend_tgt_n;
      wrap     <= wrap_n;
    end
  end

  // Status flags are decoded straight from the registered state.
  always_comb begin
    halted = (state == HALTED);
    pend   = (state == STALLED_PEND);
  end

endmodule
